// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with burst ownership and a bounded hold time.
// The owner keeps the grant while requesting, and is preempted after MAX_HOLD cycles if others wait.
module rr_hold_arbiter #(
  parameter int N        = 2,
  parameter int MAX_HOLD = 4,
  parameter int ID_W     = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    request,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id,
  output logic            preempt
);

  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] SAT =
    (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD) : {CNT_W{1'b1}};

  typedef enum logic {IDLE, OWNED} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [N-1:0]      grant_q, grant_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic              pre_q, pre_d;

  logic [N-1:0]      others;
  logic              own_req;
  logic [ID_W-1:0]   win_ptr;
  logic [ID_W-1:0]   win_nxt;

  function automatic logic [ID_W-1:0] inc(input logic [ID_W-1:0] id);
    return (id == ID_W'(N - 1)) ? '0 : id + 1'b1;
  endfunction

  // First set bit of req scanning start, start+1, ... wrapping mod N.
  function automatic logic [ID_W-1:0] rr_pick(
    input logic [N-1:0]    req,
    input logic [ID_W-1:0] start
  );
    logic [ID_W-1:0] r;
    logic            found;
    int              j;
    r     = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found = 1'b1;
        r     = ID_W'(j);
      end
    end
    return r;
  endfunction

  // The owner's own bit is masked out, so this is "everyone else waiting".
  assign others  = request & ~grant_q;
  assign own_req = request[gid_q];
  assign win_ptr = rr_pick(request, ptr_q);
  assign win_nxt = rr_pick(others, inc(gid_q));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    gid_d      = gid_q;
    pre_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|request) begin
          state_d    = OWNED;
          grant_d    = {{(N-1){1'b0}}, 1'b1} << win_ptr;
          gid_d      = win_ptr;
          ptr_d      = inc(win_ptr);
          hold_cnt_d = CNT_W'(1);
        end
      end
      OWNED: begin
        if (!own_req && (|others)) begin
          grant_d    = {{(N-1){1'b0}}, 1'b1} << win_nxt;
          gid_d      = win_nxt;
          ptr_d      = inc(win_nxt);
          hold_cnt_d = CNT_W'(1);
        end else if (!own_req) begin
          state_d    = IDLE;
          grant_d    = '0;
          gid_d      = '0;
          ptr_d      = inc(gid_q);
          hold_cnt_d = '0;
        end else if ((MAX_HOLD != 0) && (hold_cnt_q == SAT)
                     && (|others)) begin
          grant_d    = {{(N-1){1'b0}}, 1'b1} << win_nxt;
          gid_d      = win_nxt;
          ptr_d      = inc(win_nxt);
          hold_cnt_d = CNT_W'(1);
          pre_d      = 1'b1;
        end else if (hold_cnt_q != SAT) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      grant_q    <= '0;
      gid_q      <= '0;
      pre_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      gid_q      <= gid_d;
      pre_q      <= pre_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = gid_q;
  assign preempt     = pre_q;

endmodule

// File: doc/rr_hold_arbiter.md
Name: rr_hold_arbiter

Overview:
- Parameterized round-robin arbiter sharing one resource among N requesters.
- Replaces the fixed 2-requester arbiter behind the arbiter interface (request/grant vectors).
- Owner keeps the grant while its request stays high (burst ownership).
- Owner is preempted after MAX_HOLD cycles when another requester is waiting, so no requester starves.

Parameters:
- N, 2, number of requesters (N >= 2).
- MAX_HOLD, 4, max consecutive grant cycles while others wait; 0 = unlimited hold.
- ID_W, $clog2(N), width of grant_id.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- request  input  N  per-requester request level, sampled on rising clk.
- grant  output  N  registered one-hot grant; all zero when idle.
- grant_valid  output  1  registered; 1 iff grant != 0.
- grant_id  output  ID_W  registered index of current owner; 0 when idle.
- preempt  output  1  registered one-cycle pulse on a forced handover due to MAX_HOLD.

Behaviour:
- Reset (rst=0, asynchronous):
  - grant=0, grant_valid=0, grant_id=0, preempt=0.
  - ptr=0, hold_cnt=0, state=IDLE.
  - Outputs drop immediately, without waiting for clk.
- Internal state:
  - ptr (ID_W): highest-priority index.
  - hold_cnt (saturating at MAX_HOLD, or free width when MAX_HOLD=0).
  - FSM states IDLE and OWNED.
- Winner search: the first index i found scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N) with request[i]=1. The "next winner after g" uses the same scan starting at g+1 mod N and excludes g.
- Latency: request seen at edge k produces grant visible after edge k (one-cycle registered latency). No combinational path from request to grant.
- IDLE:
  - request=0: stay IDLE, outputs 0.
  - request!=0: grant winner w, grant_id=w, state=OWNED, hold_cnt=1.
- OWNED (owner g), evaluated each edge:
  - request[g]=0, others pending: hand over directly to the next winner after g. hold_cnt=1. No idle gap cycle.
  - request[g]=0, none pending: grant=0, state=IDLE, ptr=g+1 mod N.
  - request[g]=1, MAX_HOLD!=0, hold_cnt==MAX_HOLD, others pending: preempt to the next winner after g. hold_cnt=1, preempt=1 for that cycle.
  - request[g]=1, otherwise: keep grant. hold_cnt increments, saturating at MAX_HOLD.
- ptr updates to winner+1 mod N on every new grant, so the last owner always has lowest priority.
- preempt=0 on every cycle without a forced handover.
- Simultaneous owner drop and new requests: handled in the same edge; grant never goes all-zero when any request is pending.
- grant is always one-hot or zero. grant_valid and grant_id are consistent with grant in every cycle.
- Requests asserted during reset are ignored. First evaluation happens at the first rising edge after rst=1, starting from ptr=0.

Test Plan:
- N=2, MAX_HOLD=4; release reset, drive request=01 at edge 1 -> grant=01, grant_valid=1, grant_id=0 after edge 1; still 01 two edges later.
- request=11 from reset -> grant=01; drop request[0] -> grant=10 after the next edge, with no 00 cycle in between.
- request=11 held continuously -> grant=01 for 4 cycles, then 10 for 4, alternating. preempt pulses 1 cycle at each switch.
- Only request=10 held 10 cycles -> grant=10 every cycle, preempt=0 throughout, hold_cnt saturates at 4.
- Pull rst=0 mid-grant between clock edges -> grant=00, grant_valid=0 immediately. After release with request=11 -> grant=01 (ptr reset to 0).
- N=4, MAX_HOLD=0, request=1111 with each owner dropping after 2 cycles and re-asserting -> grant order 0001, 0010, 0100, 1000, 0001; never preempts.
